// File: rtl/sfft_readout_pkg.sv
// Shared types, constants and helpers for the SFFT readout scheduler.
// Optional status word is controlled by SFFT_READOUT_STATUS_EN (see top).
package sfft_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    COMMIT,
    SWAP
  } state_t;

  typedef enum logic [1:0] {
    RD_ZERO,
    RD_BANK,
    RD_STATUS
  } rd_sel_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_WORDS  = 1;

  // Sign-extend the low 'width' bits of raw to a full 32-bit word.
  function automatic logic [31:0] sext_bin(input logic [31:0] raw, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'h0 : (32'hFFFF_FFFF << width);
    return raw[width-1] ? (raw | mask) : (raw & ~mask);
  endfunction

endpackage

// File: rtl/sfft_readout_if.sv
// Host-side Avalon-style byte read port plus the frame publish pulse.
interface sfft_readout_if;
  logic        chipselect;
  logic [15:0] address;
  logic [7:0]  readdata;
  logic        frame_ready;

  modport master (
    output chipselect,
    output address,
    input  readdata,
    input  frame_ready
  );

  modport slave (
    input  chipselect,
    input  address,
    output readdata,
    output frame_ready
  );
endinterface

// File: rtl/sfft_readout_bank.sv
// Double-buffered frame store: one word write port, one byte-addressed registered read port.
// Word address MSB selects the bank; storage is split into byte lanes so each lane maps to block RAM.
module sfft_readout_bank
  import sfft_readout_pkg::*;
#(
  parameter int AW     = 9,
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic [LANE_W-1:0] i_rd_lane,
  output logic [7:0]        o_rd_byte
);

  localparam int LANES = WORD_BYTES;

  logic [LANES-1:0][7:0] w_lane_q;
  logic [LANE_W-1:0]     r_lane;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] r_mem [2**AW];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (i_wr_en) begin
          r_mem[i_wr_addr] <= i_wr_data[8*gi +: 8];
        end
        r_q <= r_mem[i_rd_addr];
      end

      assign w_lane_q[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    r_lane <= i_rd_lane;
  end

  assign o_rd_byte = w_lane_q[r_lane];

endmodule

// File: rtl/sfft_readout_scheduler.sv
// Walks the SFFT result port once per frame into the back bank, then publishes it when the host is idle.
// Define SFFT_READOUT_STATUS_EN to add the overrun/status word after the last bin.
module sfft_readout_scheduler
  import sfft_readout_pkg::*;
#(
  parameter int NFFT_LOG2 = 7,
  parameter int BIN_W     = 32,
  parameter int TIME_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sfft_valid,
  output logic [NFFT_LOG2-1:0] sfft_addr,
  input  logic [BIN_W-1:0]     sfft_data,
  sfft_readout_if.slave        host
);

  localparam int NFFT   = 1 << NFFT_LOG2;
  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int WI_W   = NFFT_LOG2 + 1;
  localparam int AW     = WI_W + 1;
  localparam int HA_W   = 16 - LANE_W;

  localparam logic [HA_W-1:0]      LAST_BANK_WORD = HA_W'(NFFT + HDR_WORDS - 1);
  localparam logic [NFFT_LOG2-1:0] K_LAST         = '1;
  localparam logic [NFFT_LOG2-1:0] K_ONE          = NFFT_LOG2'(1);
  localparam logic [WI_W-1:0]      W_ONE          = WI_W'(1);
  localparam logic [TIME_W-1:0]    CNT_ONE        = TIME_W'(1);

  state_t               r_state;
  logic                 r_valid_q;
  logic [NFFT_LOG2-1:0] r_k;
  logic [NFFT_LOG2-1:0] r_sfft_addr;
  logic                 r_front;
  logic [1:0]           r_bank_valid;
  logic [TIME_W-1:0]    r_frame_count;
  logic                 r_frame_ready;
  rd_sel_t              r_rd_sel;

  logic                 w_start;
  logic [TIME_W-1:0]    w_count_next;
  logic [WI_W-1:0]      w_k_word;
  logic                 w_wr_en;
  logic [AW-1:0]        w_wr_addr;
  logic [31:0]          w_wr_data;
  logic [HA_W-1:0]      w_word;
  logic [LANE_W-1:0]    w_lane;
  logic [AW-1:0]        w_rd_addr;
  logic [7:0]           w_bank_byte;
  logic [7:0]           w_readdata;

  assign w_start      = sfft_valid & ~r_valid_q;
  assign w_count_next = r_frame_count + CNT_ONE;
  assign w_k_word     = {1'b0, r_k} + W_ONE;
  assign w_word       = host.address[15:LANE_W];
  assign w_lane       = host.address[LANE_W-1:0];
  assign w_rd_addr    = {r_front, w_word[WI_W-1:0]};

  // Bank contents are never cleared; r_bank_valid masks a bank until it has been published.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_valid_q     <= 1'b0;
      r_k           <= '0;
      r_sfft_addr   <= '0;
      r_front       <= 1'b0;
      r_bank_valid  <= 2'b00;
      r_frame_count <= '0;
      r_frame_ready <= 1'b0;
    end else begin
      r_valid_q     <= sfft_valid;
      r_frame_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= FETCH;
            r_sfft_addr <= '0;
            r_k         <= '0;
          end
        end
        FETCH: begin
          r_sfft_addr <= r_k;
          r_state     <= CAPTURE;
        end
        CAPTURE: begin
          r_sfft_addr <= r_k + K_ONE;
          if (r_k == K_LAST) begin
            r_state <= COMMIT;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        COMMIT: begin
          r_frame_count <= w_count_next;
          r_state       <= SWAP;
        end
        SWAP: begin
          if (!host.chipselect) begin
            r_front               <= ~r_front;
            r_bank_valid[~r_front] <= 1'b1;
            r_frame_ready         <= 1'b1;
            r_state               <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = {~r_front, w_k_word};
    w_wr_data = sext_bin(32'(sfft_data), BIN_W);
    case (r_state)
      CAPTURE: w_wr_en = 1'b1;
      COMMIT: begin
        w_wr_en   = 1'b1;
        w_wr_addr = {~r_front, {WI_W{1'b0}}};
        w_wr_data = 32'(w_count_next);
      end
      default: w_wr_en = 1'b0;
    endcase
  end

  sfft_readout_bank #(
    .AW    (AW),
    .LANE_W(LANE_W)
  ) u_bank (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(w_wr_data),
    .i_rd_addr(w_rd_addr),
    .i_rd_lane(w_lane),
    .o_rd_byte(w_bank_byte)
  );

`ifdef SFFT_READOUT_STATUS_EN
  localparam logic [HA_W-1:0] STATUS_WORD = HA_W'(NFFT + HDR_WORDS);

  logic [15:0] r_overrun_cnt;
  logic [7:0]  r_status_byte;
  logic [31:0] w_status;

  assign w_status = {14'd0, (r_state != IDLE), (r_state == SWAP), r_overrun_cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun_cnt <= '0;
    end else if (w_start && (r_state != IDLE) && (r_overrun_cnt != 16'hFFFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sel      <= RD_ZERO;
      r_status_byte <= 8'h00;
    end else begin
      r_rd_sel <= RD_ZERO;
      if (w_word <= LAST_BANK_WORD) begin
        if (r_bank_valid[r_front]) r_rd_sel <= RD_BANK;
      end else if (w_word == STATUS_WORD) begin
        r_rd_sel      <= RD_STATUS;
        r_status_byte <= w_status[{w_lane, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    case (r_rd_sel)
      RD_BANK:   w_readdata = w_bank_byte;
      RD_STATUS: w_readdata = r_status_byte;
      default:   w_readdata = 8'h00;
    endcase
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sel <= RD_ZERO;
    end else if ((w_word <= LAST_BANK_WORD) && r_bank_valid[r_front]) begin
      r_rd_sel <= RD_BANK;
    end else begin
      r_rd_sel <= RD_ZERO;
    end
  end

  always_comb begin
    w_readdata = (r_rd_sel == RD_BANK) ? w_bank_byte : 8'h00;
  end
`endif

  assign sfft_addr        = r_sfft_addr;
  assign host.readdata    = w_readdata;
  assign host.frame_ready = r_frame_ready;

endmodule

// File: tb/tb_sfft_readout_scheduler.sv
// Directed bench for sfft_readout_scheduler with NFFT=8; SFFT model returns 0x1000+addr.
module tb_sfft_readout_scheduler;

  logic        clk;
  logic        reset;
  logic        sfft_valid;
  logic [2:0]  sfft_addr;
  logic [31:0] sfft_data;
  int          n_checks;
  int          n_bad;

  sfft_readout_if bus ();

  sfft_readout_scheduler #(
    .NFFT_LOG2(3),
    .BIN_W    (32),
    .TIME_W   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sfft_valid(sfft_valid),
    .sfft_addr (sfft_addr),
    .sfft_data (sfft_data),
    .host      (bus.slave)
  );

  // Bin for the address registered on one edge is sampled by the scheduler on the next edge.
  assign sfft_data = 32'h1000 + {29'd0, sfft_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic rd_check(input logic [15:0] addr, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.address = addr;
    @(posedge clk);
    #1;
    check(name, {24'd0, bus.readdata}, {24'd0, exp});
  endtask

  // Raise sfft_valid, optionally re-raise it after edge dup_at, and count edges to frame_ready.
  task automatic run_frame(input int dup_at, output int cyc);
    @(negedge clk);
    sfft_valid = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      cyc = i;
      if (i == dup_at) sfft_valid = 1'b1;
      else if (i == 1 || i == dup_at + 1) sfft_valid = 1'b0;
      if (bus.frame_ready) break;
      if (i == 200) cyc = -1;
    end
    sfft_valid = 1'b0;
  endtask

  task automatic idle_no_ready(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_ready) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int seen;
    n_checks = 0;
    n_bad    = 0;

    vecs[0]  = '{16'd0,      8'h01};
    vecs[1]  = '{16'd1,      8'h00};
    vecs[2]  = '{16'd2,      8'h00};
    vecs[3]  = '{16'd3,      8'h00};
    vecs[4]  = '{16'd4,      8'h00};
    vecs[5]  = '{16'd5,      8'h10};
    vecs[6]  = '{16'd16,     8'h03};
    vecs[7]  = '{16'd17,     8'h10};
    vecs[8]  = '{16'd18,     8'h00};
    vecs[9]  = '{16'd19,     8'h00};
    vecs[10] = '{16'd32,     8'h07};
    vecs[11] = '{16'd33,     8'h10};
    vecs[12] = '{16'd40,     8'h00};
    vecs[13] = '{16'hFFFF,   8'h00};

    // 1. reset state
    reset          = 1'b1;
    sfft_valid     = 1'b0;
    bus.chipselect = 1'b0;
    bus.address    = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_frame_ready", {31'd0, bus.frame_ready}, 0);
    check("rst_sfft_addr", {29'd0, sfft_addr}, 0);
    for (int a = 0; a < 40; a++) rd_check(16'(a), 8'h00, $sformatf("rst_byte_%0d", a));

    // 2. first frame latency and word map
    run_frame(0, cyc);
    check("f1_latency", cyc, 12);
    check("f1_sfft_addr_wrapped", {29'd0, sfft_addr}, 0);
    for (int v = 0; v < 14; v++)
      rd_check(vecs[v].addr, vecs[v].exp, $sformatf("f1_byte_%0h", vecs[v].addr));

    // 3. host busy blocks the swap
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.address    = 16'd0;
    sfft_valid     = 1'b1;
    seen = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) sfft_valid = 1'b0;
      if (bus.frame_ready) seen++;
    end
    check("hold_no_ready", seen, 0);
    check("hold_old_count", {24'd0, bus.readdata}, 1);
`ifdef SFFT_READOUT_STATUS_EN
    rd_check(16'd38, 8'h03, "hold_status_pending_busy");
`endif
    rd_check(16'd0, 8'h01, "hold_count_again");
    @(negedge clk);
    bus.chipselect = 1'b0;
    @(posedge clk);
    #1;
    check("swap_ready_pulse", {31'd0, bus.frame_ready}, 1);
    check("swap_edge_old_front", {24'd0, bus.readdata}, 1);
    @(posedge clk);
    #1;
    check("swap_ready_one_cycle", {31'd0, bus.frame_ready}, 0);
    check("swap_new_count", {24'd0, bus.readdata}, 2);

    // 4. second start during CAPTURE is dropped
    run_frame(5, cyc);
    check("ovr_latency", cyc, 12);
    idle_no_ready(20, "ovr_no_extra_frame");
    rd_check(16'd0, 8'h03, "ovr_count");
    rd_check(16'd24, 8'h05, "ovr_bin5_lo");
    rd_check(16'd25, 8'h10, "ovr_bin5_hi");
`ifdef SFFT_READOUT_STATUS_EN
    rd_check(16'd36, 8'h01, "ovr_status_lo");
    rd_check(16'd37, 8'h00, "ovr_status_hi");
`else
    rd_check(16'd36, 8'h00, "ovr_no_status");
`endif

    // 4b. start coinciding with SWAP->IDLE is dropped
    run_frame(11, cyc);
    check("swapedge_latency", cyc, 12);
    idle_no_ready(20, "swapedge_no_extra_frame");
    rd_check(16'd0, 8'h04, "swapedge_count");
`ifdef SFFT_READOUT_STATUS_EN
    rd_check(16'd36, 8'h02, "swapedge_status_lo");
`endif

    // 5. reset mid-CAPTURE with k=4
    @(negedge clk);
    sfft_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) sfft_valid = 1'b0;
    end
    check("mid_capture_addr", {29'd0, sfft_addr}, 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_sfft_addr", {29'd0, sfft_addr}, 0);
    check("mid_rst_frame_ready", {31'd0, bus.frame_ready}, 0);
    check("mid_rst_readdata", {24'd0, bus.readdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 40; a += 3) rd_check(16'(a), 8'h00, $sformatf("mid_rst_byte_%0d", a));
    idle_no_ready(5, "mid_rst_idle");
    run_frame(0, cyc);
    check("post_rst_latency", cyc, 12);
    rd_check(16'd0, 8'h01, "post_rst_count");
    rd_check(16'd32, 8'h07, "post_rst_bin7_lo");
    rd_check(16'd33, 8'h10, "post_rst_bin7_hi");

    // 6. out-of-range addresses
    rd_check(16'hFFFF, 8'h00, "oor_ffff");
    rd_check(16'd40, 8'h00, "oor_40");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
